// File: rtl/fp16_float_adder_pkg.sv
// fp16_float_adder_pkg: binary16 format constants and field layout shared by the adder.
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS = 15;
  localparam int EXP_MAX = 31;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;
  localparam logic [15:0] NINF = 16'hFC00;
  typedef struct packed {
    logic sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp16_t;
endpackage

// File: rtl/fp16_float_adder_if.sv
// fp16_float_adder_if: operand and result bundle between the datapath and the adder.
interface fp16_float_adder_if;
  import fp16_pkg::*;
  fp16_t input1;
  fp16_t input2;
  fp16_t result;
  modport master(output input1, output input2, input result);
  modport slave(input input1, input input2, output result);
endinterface

// File: rtl/fp16_float_adder_lzc.sv
// fp_lzc16: leading-zero count of the 14-bit pre-normalized significand (14 when all zero).
module fp_lzc16 (
  input  logic [13:0] value,
  output logic [3:0]  count
);
  always_comb begin
    count = 4'd14;
    for (int i = 0; i < 14; i++)
      if (value[i]) count = 4'(13 - i);
  end
endmodule

// File: rtl/fp16_float_adder.sv
// fp16_float_adder: binary16 a+b, round-to-nearest-even with gradual underflow, one register stage.
module fp16_float_adder
  import fp16_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  fp16_float_adder_if.slave io
);
  fp16_t a, b, big, nxt;
  logic swap, eff_sub, rnd;
  logic a_nan, b_nan, a_inf, b_inf;
  logic [14:0] small_mag;
  logic [4:0] eb, es, diff, lim;
  logic [10:0] mb, ms;
  logic [26:0] shf;
  logic [13:0] al, norm;
  logic [14:0] bx, sum;
  logic [3:0] lz, shl;
  logic [5:0] en, ef;
  logic [11:0] mr;
  logic [9:0] ff;
  assign a = io.input1;
  assign b = io.input2;
  assign a_nan = (&a.exp) && (|a.frac);
  assign b_nan = (&b.exp) && (|b.frac);
  assign a_inf = (&a.exp) && !(|a.frac);
  assign b_inf = (&b.exp) && !(|b.frac);
  assign eff_sub = a.sign ^ b.sign;
  assign swap = b[14:0] > a[14:0];
  assign big = swap ? b : a;
  assign small_mag = swap ? a[14:0] : b[14:0];
  // subnormals share the minimum exponent and have no hidden bit
  assign eb = big.exp == '0 ? 5'd1 : big.exp;
  assign es = small_mag[14:10] == '0 ? 5'd1 : small_mag[14:10];
  assign mb = {big.exp != '0, big.frac};
  assign ms = {small_mag[14:10] != '0, small_mag[9:0]};
  assign diff = eb - es;
  // shifts of 13 or more push every bit into sticky through the wide shifter
  assign shf = {ms, 16'b0} >> diff;
  assign al = {shf[26:14], |shf[13:0]};
  assign bx = {1'b0, mb, 3'b0};
  assign sum = eff_sub ? bx - {1'b0, al} : bx + {1'b0, al};
  fp_lzc16 u_lzc (.value(sum[13:0]), .count(lz));
  assign lim = eb - 5'd1;
  assign shl = {1'b0, lz} > lim ? lim[3:0] : lz;
  assign norm = sum[14] ? {sum[14:2], |sum[1:0]} : sum[13:0] << shl;
  assign en = sum[14] ? {1'b0, eb} + 6'd1 : {1'b0, eb} - {2'b0, shl};
  assign rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign mr = {1'b0, norm[13:3]} + {11'b0, rnd};
  assign ef = mr[11] ? en + 6'd1 : (mr[10] ? en : 6'd0);
  assign ff = mr[11] ? mr[10:1] : mr[9:0];
  always_comb
    nxt = (a_nan || b_nan || (a_inf && b_inf && eff_sub)) ? QNAN :
          a_inf ? a :
          b_inf ? b :
          sum == '0 ? {a.sign & b.sign, 15'b0} :
          ef >= 6'(EXP_MAX) ? (big.sign ? NINF : PINF) :
          {big.sign, ef[4:0], ff};
  always_ff @(posedge clk)
    io.result <= !rst_n ? '0 : nxt;
endmodule

// File: tb/tb_fp16_float_adder.sv
// tb_fp16_float_adder: directed vectors plus back-to-back random pairs against a real-valued model.
module tb_fp16_float_adder;
  import fp16_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  fp16_float_adder_if io();
  fp16_float_adder dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic apply(input string tag, input logic [15:0] x, input logic [15:0] y, input logic [15:0] e);
    io.input1 = x;
    io.input2 = y;
    @(posedge clk);
    #1;
    check(tag, io.result, e);
  endtask
  function automatic real to_real(input logic [15:0] v);
    real r;
    int e;
    r = (v[14:10] == 5'd0) ? real'(v[9:0]) : real'(1024 + int'(v[9:0]));
    e = (v[14:10] == 5'd0) ? -24 : int'(v[14:10]) - 25;
    for (int i = 0; i < -e; i++) r = r / 2.0;
    for (int i = 0; i < e; i++) r = r * 2.0;
    return v[15] ? -r : r;
  endfunction
  function automatic logic [15:0] to_fp16(input real s);
    logic sg;
    real mag, p, m, fr;
    longint fl;
    int e, ex;
    sg = s < 0.0;
    mag = sg ? -s : s;
    if (mag == 0.0) return 16'h0000;
    p = 1.0 / 16384.0;
    e = -14;
    while (mag >= 2.0 * p && e < 15) begin
      p = p * 2.0;
      e++;
    end
    m = mag / p * 1024.0;
    fl = longint'($floor(m));
    fr = m - real'(fl);
    if (fr > 0.5 || (fr == 0.5 && fl[0])) fl++;
    if (fl == 2048) begin
      fl = 1024;
      e++;
    end
    ex = (fl >= 1024) ? e + 15 : 0;
    if (ex >= 31) return sg ? 16'hFC00 : 16'h7C00;
    return {sg, 5'(ex), fl[9:0]};
  endfunction
  function automatic logic [15:0] rnd_op();
    logic [15:0] r;
    r = {1'($urandom), 5'($urandom_range(0, 14)), 10'($urandom)};
    if (r[14:0] == 15'd0) r[0] = 1'b1;
    return r;
  endfunction
  initial begin
    logic [15:0] x, y;
    io.input1 = 16'h3C00;
    io.input2 = 16'h3C00;
    @(posedge clk);
    #1;
    check("reset", io.result, 16'h0000);
    rst_n = 1'b1;
    apply("basic_add", 16'h3C00, 16'h3C00, 16'h4000);
    apply("mixed_sign", 16'h3E00, 16'hB800, 16'h3C00);
    apply("cancel", 16'h3C00, 16'hBC00, 16'h0000);
    apply("tie_odd", 16'h3C01, 16'h1000, 16'h3C02);
    apply("tie_even", 16'h3C00, 16'h1000, 16'h3C00);
    apply("overflow", 16'h7BFF, 16'h7BFF, 16'h7C00);
    apply("sub_add", 16'h0001, 16'h0001, 16'h0002);
    apply("sub_to_norm", 16'h03FF, 16'h0001, 16'h0400);
    apply("norm_to_sub", 16'h0400, 16'h8001, 16'h03FF);
    apply("inf_minus_inf", 16'h7C00, 16'hFC00, 16'h7E00);
    apply("nan_a", 16'h7E00, 16'h3C00, 16'h7E00);
    apply("nan_b", 16'h3C00, 16'h7D01, 16'h7E00);
    apply("inf_fin", 16'h7C00, 16'h3C00, 16'h7C00);
    apply("fin_ninf", 16'h3C00, 16'hFC00, 16'hFC00);
    apply("inf_inf", 16'h7C00, 16'h7C00, 16'h7C00);
    apply("neg_zeros", 16'h8000, 16'h8000, 16'h8000);
    apply("mixed_zeros", 16'h8000, 16'h0000, 16'h0000);
    apply("neg_result", 16'hC000, 16'h3C00, 16'hBC00);
    rst_n = 1'b0;
    apply("reset_again", 16'h3C00, 16'h3C00, 16'h0000);
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      x = rnd_op();
      y = rnd_op();
      apply("random", x, y, to_fp16(to_real(x) + to_real(y)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
